// File: rtl/m72_pkg.sv
// Shared M72 sound-path definitions: channel limits, idle vector and the
// channel-select width helper used by the command mailbox.
package m72_pkg;

  localparam int SND_NCH_MAX = 4;

  typedef logic [1:0] snd_ch_t;

  localparam logic [7:0] SND_VEC_IDLE = 8'hFF;

  // Width of a channel-select field; a single channel still needs one bit.
  function automatic int snd_cw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/snd_cmd_mailbox_if.sv
// Host/sound-side bus of the command mailbox. Reply-latch signals exist only
// when SND_REPLY_EN is defined.
interface snd_cmd_mailbox_if #(parameter int NCH = 2);
  import m72_pkg::*;

  localparam int CW = snd_cw(NCH);

  logic           pause;
  logic           host_wr;
  logic [CW-1:0]  host_ch;
  logic [7:0]     host_data;
  logic [NCH-1:0] host_full;
  logic [CW-1:0]  snd_ch;
  logic [7:0]     snd_data;
  logic           snd_pop;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] overflow;
  logic           ext_irq_n;
  logic           int_n;
  logic           nmi_n;
  logic [7:0]     int_vector;
`ifdef SND_REPLY_EN
  logic           snd_reply_wr;
  logic [7:0]     snd_reply_data;
  logic           host_reply_ack;
  logic [7:0]     host_reply;
  logic           host_reply_valid;
`endif

  modport master (
    output pause, host_wr, host_ch, host_data, snd_ch, snd_pop, ext_irq_n,
    input  host_full, snd_data, pending, overflow, int_n, nmi_n, int_vector
`ifdef SND_REPLY_EN
    , output snd_reply_wr, snd_reply_data, host_reply_ack
    , input  host_reply, host_reply_valid
`endif
  );

  modport slave (
    input  pause, host_wr, host_ch, host_data, snd_ch, snd_pop, ext_irq_n,
    output host_full, snd_data, pending, overflow, int_n, nmi_n, int_vector
`ifdef SND_REPLY_EN
    , input  snd_reply_wr, snd_reply_data, host_reply_ack
    , output host_reply, host_reply_valid
`endif
  );

endinterface

// File: rtl/snd_cmd_fifo.sv
// One mailbox channel: byte FIFO of DEPTH entries with a sticky overflow flag.
// Push and pop arrive already qualified by pause and channel decode.
module snd_cmd_fifo
  import m72_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK_32M,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_ovf;

  logic            w_do_pop;
  logic            w_do_push;
  logic [CNTW-1:0] w_count_nxt;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign ovf   = r_ovf;
  assign dout  = empty ? SND_VEC_IDLE : r_mem[r_rd_ptr];

  // A pop on a full channel frees the slot the simultaneous push lands in;
  // a pop on an empty channel is dropped so the push still wins.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_comb begin
    // NOTE: default first so every path assigns w_count_nxt; otherwise a latch is inferred.
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)
      w_count_nxt = r_count + 1'b1;
    else if (w_do_pop && !w_do_push)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge CLK_32M) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      if (push && full && !w_do_pop)
        r_ovf <= 1'b1;
    end
  end

  // NOTE: storage is not reset; an empty count already masks stale bytes.
  always_ff @(posedge CLK_32M) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/snd_cmd_mailbox.sv
// Main-CPU -> sound-CPU command mailbox: NCH byte FIFOs routed to Z80 INT/NMI
// plus the IM0 vector. SND_REPLY_EN adds a sound -> host reply latch.
module snd_cmd_mailbox
  import m72_pkg::*;
#(
  parameter int             NCH      = 2,
  parameter int             DEPTH    = 4,
  parameter logic [NCH-1:0] NMI_MASK = 2'b10
) (
  input logic               CLK_32M,
  input logic               reset,
  snd_cmd_mailbox_if.slave  bus
);

  localparam int CW    = snd_cw(NCH);
  localparam int NSLOT = 1 << CW;

  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_ovf;
  logic [NCH-1:0] w_pending;
  logic [7:0]     w_dout [NSLOT];
  logic           w_p0_int;

  // Select codes beyond NCH get no FIFO and read back as idle.
  for (genvar g = 0; g < NSLOT; g++) begin : g_ch
    if (g < NCH) begin : g_fifo
      assign w_push[g] = bus.host_wr & ~bus.pause & (bus.host_ch == CW'(g));
      assign w_pop[g]  = bus.snd_pop & ~bus.pause & (bus.snd_ch == CW'(g));

      snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK_32M (CLK_32M),
        .reset   (reset),
        .push    (w_push[g]),
        .pop     (w_pop[g]),
        .din     (bus.host_data),
        .dout    (w_dout[g]),
        .full    (w_full[g]),
        .empty   (w_empty[g]),
        .ovf     (w_ovf[g])
      );
    end else begin : g_idle
      assign w_dout[g] = SND_VEC_IDLE;
    end
  end

  assign w_pending     = ~w_empty;
  assign bus.pending   = w_pending;
  assign bus.host_full = w_full;
  assign bus.overflow  = w_ovf;
  assign bus.snd_data  = w_dout[bus.snd_ch];

  assign bus.int_n = ~((|(w_pending & ~NMI_MASK)) | ~bus.ext_irq_n);
  assign bus.nmi_n = ~(|(w_pending & NMI_MASK));

  // Only channel 0 shapes the vector, matching the M72 RST encoding.
  assign w_p0_int       = w_pending[0] & ~NMI_MASK[0];
  assign bus.int_vector = {2'b11, ~w_p0_int, bus.ext_irq_n, 4'b1111};

`ifdef SND_REPLY_EN
  logic [7:0] r_reply;
  logic       r_reply_valid;

  // A write in the same cycle as an ack keeps the latch valid with new data.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      r_reply       <= 8'h00;
      r_reply_valid <= 1'b0;
    end else if (!bus.pause) begin
      if (bus.snd_reply_wr) begin
        r_reply       <= bus.snd_reply_data;
        r_reply_valid <= 1'b1;
      end else if (bus.host_reply_ack) begin
        r_reply_valid <= 1'b0;
      end
    end
  end

  assign bus.host_reply       = r_reply;
  assign bus.host_reply_valid = r_reply_valid;
`endif

endmodule
